// File: rtl/hash_serializer_if.sv
// Hash ingress / word egress bundle for hash_serializer.
// slave: the serializer itself. master: the environment feeding hashes
// and sinking words.
interface hash_serializer_if #(
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             i_valid;
  logic [127:0]     i_hash;
  logic [31:0]      o_data;
  logic             o_valid;
  logic             o_ready;
  logic             o_first;
  logic             o_last;
  logic             o_overflow;
  logic [15:0]      o_drop_cnt;
  logic [LVL_W-1:0] o_level;

  modport slave (
    input  i_valid, i_hash, o_ready,
    output o_data, o_valid, o_first, o_last, o_overflow, o_drop_cnt, o_level
  );

  modport master (
    output i_valid, i_hash, o_ready,
    input  o_data, o_valid, o_first, o_last, o_overflow, o_drop_cnt, o_level
  );
endinterface

// File: rtl/hash_serializer.sv
// Buffers 128-bit hashes in a small circular FIFO and emits each one as
// four 32-bit beats on a valid/ready link. Hashes arriving while the
// buffer is full (and no final-beat pop frees a slot) are dropped and counted.
module hash_serializer #(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  hash_serializer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [127:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       beat_q, beat_d;
  logic [0:0]       state_q, state_d;
  logic [31:0]      o_data_q, o_data_d;
  logic             o_valid_q, o_valid_d;
  logic             o_first_q, o_first_d;
  logic             o_last_q, o_last_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic             hs_s, pop_s, full_s, wr_acc_s, drop_s;
  logic [127:0]     head_s;

  // Pick beat b of a hash according to the configured word order.
  function automatic logic [31:0] sel_word(input logic [127:0] h, input logic [1:0] b);
    logic [1:0] idx;
    idx = MSB_FIRST ? (2'd3 - b) : b;
    return h[{idx, 5'd0} +: 32];
  endfunction

  // Next-state logic: FIFO bookkeeping, egress FSM and output precompute.
  always_comb begin
    hs_s     = o_valid_q && bus.o_ready;
    pop_s    = hs_s && (beat_q == 2'd3);
    full_s   = (count_q == CNT_W'(DEPTH));
    wr_acc_s = bus.i_valid && (!full_s || pop_s);
    drop_s   = bus.i_valid && full_s && !pop_s;

    wr_ptr_d = wr_acc_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s    ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

    case ({wr_acc_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    beat_d = hs_s ? (beat_q + 2'd1) : beat_q;

    case (state_q)
      ST_IDLE: begin
        // Looking at the post-write count lets a hash written into an
        // empty buffer appear on the link in the very next cycle.
        if (count_d != '0) state_d = ST_SEND;
        else               state_d = ST_IDLE;
      end
      ST_SEND: begin
        if (pop_s && (count_d == '0)) state_d = ST_IDLE;
        else                          state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase

    // The next head entry may be the one being written this very cycle
    // (empty buffer, or last entry popping as a new one arrives).
    if (wr_acc_s && (wr_ptr_q == rd_ptr_d)) head_s = bus.i_hash;
    else                                    head_s = mem_q[rd_ptr_d];

    o_valid_d = (state_d == ST_SEND);
    if (o_valid_d) o_data_d = sel_word(head_s, beat_d);
    else           o_data_d = 32'h0;
    o_first_d = o_valid_d && (beat_d == 2'd0);
    o_last_d  = o_valid_d && (beat_d == 2'd3);

    overflow_d = overflow_q || drop_s;
    if (drop_s && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    else                                    drop_cnt_d = drop_cnt_q;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_q     <= 2'd0;
      state_q    <= ST_IDLE;
      o_data_q   <= 32'h0;
      o_valid_q  <= 1'b0;
      o_first_q  <= 1'b0;
      o_last_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'h0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      state_q    <= state_d;
      o_data_q   <= o_data_d;
      o_valid_q  <= o_valid_d;
      o_first_q  <= o_first_d;
      o_last_q   <= o_last_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Hash storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc_s) begin
      mem_q[wr_ptr_q] <= bus.i_hash;
    end
  end

  assign bus.o_data     = o_data_q;
  assign bus.o_valid    = o_valid_q;
  assign bus.o_first    = o_first_q;
  assign bus.o_last     = o_last_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_drop_cnt = drop_cnt_q;
  assign bus.o_level    = count_q;
endmodule

// File: tb/tb_hash_serializer.sv
// Directed self-checking bench for hash_serializer (DEPTH=4, MSB_FIRST=1).
module tb_hash_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  hash_serializer_if #(.DEPTH(4)) bus ();
  hash_serializer #(.DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Compare one observed value to its expectation and count it.
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mkh(input int k);
    return {32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k),
            32'hC000_0000 + 32'(k), 32'hD000_0000 + 32'(k)};
  endfunction

  // Expected MSB-first beat b of hash h.
  function automatic logic [31:0] wd(input logic [127:0] h, input int b);
    logic [127:0] t;
    t = h >> (32 * (3 - b));
    return t[31:0];
  endfunction

  initial begin
    logic [127:0] h;
    logic [31:0]  pd;
    logic         pf, pl;
    int           k;
    int           pat [7];
    int           order [5];

    bus.i_valid = 1'b0;
    bus.i_hash  = 128'h0;
    bus.o_ready = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_data",  bus.o_data, 32'h0);
    check("rst_first", bus.o_first, 1'b0);
    check("rst_last",  bus.o_last, 1'b0);
    check("rst_ovf",   bus.o_overflow, 1'b0);
    check("rst_drop",  bus.o_drop_cnt, 16'h0);
    check("rst_level", bus.o_level, 3'd0);
    rst = 1'b0;
    tick();

    // Single hash, sink always ready
    h = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    bus.o_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_hash  = h;
    tick();
    bus.i_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      check("s_valid", bus.o_valid, 1'b1);
      check("s_data",  bus.o_data, (b == 0) ? 32'h00112233 : (b == 1) ? 32'h44556677 :
                                   (b == 2) ? 32'h8899AABB : 32'hCCDDEEFF);
      check("s_first", bus.o_first, (b == 0));
      check("s_last",  bus.o_last, (b == 3));
      check("s_level", bus.o_level, 3'd1);
      tick();
    end
    check("s_idle_valid", bus.o_valid, 1'b0);
    check("s_idle_level", bus.o_level, 3'd0);

    // Same hash with ready toggled 1,0,0,1,1,0,1
    pat = '{1, 0, 0, 1, 1, 0, 1};
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_hash  = h;
    tick();
    bus.i_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      bus.o_ready = pat[i][0];
      check("t_valid", bus.o_valid, 1'b1);
      check("t_data",  bus.o_data, wd(h, k));
      check("t_first", bus.o_first, (k == 0));
      check("t_last",  bus.o_last, (k == 3));
      pd = bus.o_data;
      pf = bus.o_first;
      pl = bus.o_last;
      tick();
      if (pat[i] != 0) begin
        k++;
      end else begin
        check("t_stall_data",  bus.o_data, pd);
        check("t_stall_first", bus.o_first, pf);
        check("t_stall_last",  bus.o_last, pl);
      end
    end
    check("t_done_valid", bus.o_valid, 1'b0);
    check("t_done_level", bus.o_level, 3'd0);

    // Overflow: six hashes into a 4-deep buffer with sink stalled
    bus.o_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      bus.i_valid = 1'b1;
      bus.i_hash  = mkh(j);
      tick();
    end
    bus.i_valid = 1'b0;
    check("o_level", bus.o_level, 3'd4);
    check("o_drop",  bus.o_drop_cnt, 16'd2);
    check("o_ovf",   bus.o_overflow, 1'b1);
    check("o_head",  bus.o_data, wd(mkh(0), 0));
    // Drain; write H6 coincident with H0's final-beat handshake while full
    order = '{0, 1, 2, 3, 6};
    bus.o_ready = 1'b1;
    for (int w = 0; w < 20; w++) begin
      check("o_valid", bus.o_valid, 1'b1);
      check("o_data",  bus.o_data, wd(mkh(order[w / 4]), w % 4));
      if (w == 3) begin
        bus.i_valid = 1'b1;
        bus.i_hash  = mkh(6);
      end
      tick();
      bus.i_valid = 1'b0;
      if (w == 3) begin
        check("o_coinc_drop",  bus.o_drop_cnt, 16'd2);
        check("o_coinc_level", bus.o_level, 3'd4);
      end
    end
    check("o_end_valid", bus.o_valid, 1'b0);
    check("o_end_level", bus.o_level, 3'd0);

    // Reset during beat 2 with three hashes queued
    bus.o_ready = 1'b0;
    for (int j = 10; j < 13; j++) begin
      bus.i_valid = 1'b1;
      bus.i_hash  = mkh(j);
      tick();
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    tick();
    tick();
    check("r_beat2", bus.o_data, wd(mkh(10), 2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_valid", bus.o_valid, 1'b0);
    check("r_level", bus.o_level, 3'd0);
    check("r_drop",  bus.o_drop_cnt, 16'd0);
    check("r_ovf",   bus.o_overflow, 1'b0);
    check("r_last",  bus.o_last, 1'b0);
    bus.i_valid = 1'b1;
    bus.i_hash  = mkh(15);
    tick();
    bus.i_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      check("r_fresh_data",  bus.o_data, wd(mkh(15), b));
      check("r_fresh_first", bus.o_first, (b == 0));
      tick();
    end
    check("r_fresh_idle", bus.o_valid, 1'b0);

    // Streaming: eight hashes every 4 cycles, no bubbles
    bus.o_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      bus.i_valid = ((c % 4) == 0);
      bus.i_hash  = mkh(20 + c / 4);
      tick();
      check("st_valid", bus.o_valid, 1'b1);
      check("st_data",  bus.o_data, wd(mkh(20 + c / 4), c % 4));
      check("st_lvl_le2", (bus.o_level <= 3'd2), 1'b1);
    end
    bus.i_valid = 1'b0;
    tick();
    check("st_idle", bus.o_valid, 1'b0);
    check("st_drop", bus.o_drop_cnt, 16'd0);

    // Drop counter saturation: fill, then 65540 drops
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_hash  = mkh(40);
    for (int n = 0; n < 14; n++) tick();
    check("sat_mid", bus.o_drop_cnt, 16'd10);
    for (int n = 0; n < 65530; n++) tick();
    bus.i_valid = 1'b0;
    check("sat_cnt", bus.o_drop_cnt, 16'hFFFF);
    check("sat_ovf", bus.o_overflow, 1'b1);
    check("sat_lvl", bus.o_level, 3'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
